// File: rtl/alu_uart_interface.sv
// Frames three UART bytes (A, B, opcode) onto the ALU inputs, then sends the ALU result
// back to the UART transmitter. Idle partial frames are dropped after TIMEOUT cycles.
module alu_uart_interface #(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [SIZE-1:0] rx_data,
  input  logic [SIZE-1:0] alu_result,
  input  logic            tx_done_tick,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  output logic [5:0]      alu_op,
  output logic [SIZE-1:0] tx_data,
  output logic            tx_start,
  output logic            busy,
  output logic            timeout_tick
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    CALC,
    WAIT_TX
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            mid_frame;
  logic            to_expire;

  assign mid_frame = (state == WAIT_B) || (state == WAIT_OP);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign to_expire = (TIMEOUT != 0) && mid_frame && !rx_done_tick && (to_cnt == TO_LAST);
  assign busy      = (state == CALC) || (state == WAIT_TX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_A;
      to_cnt       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      timeout_tick <= 1'b0;
    end else begin
      tx_start     <= 1'b0;
      timeout_tick <= 1'b0;
      case (state)
        WAIT_A: begin
          to_cnt <= '0;
          if (rx_done_tick) begin
            alu_a <= rx_data;
            state <= WAIT_B;
          end
        end
        WAIT_B, WAIT_OP: begin
          if (rx_done_tick) begin
            to_cnt <= '0;
            if (state == WAIT_B) begin
              alu_b <= rx_data;
              state <= WAIT_OP;
            end else begin
              alu_op <= rx_data[5:0];
              state  <= CALC;
            end
          end else if (to_expire) begin
            to_cnt       <= '0;
            timeout_tick <= 1'b1;
            state        <= WAIT_A;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // ALU inputs have been stable for one cycle; capture its result.
        CALC: begin
          to_cnt   <= '0;
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          state    <= WAIT_TX;
        end
        WAIT_TX: begin
          to_cnt <= '0;
          if (tx_done_tick) state <= WAIT_A;
        end
        default: begin
          to_cnt <= '0;
          state  <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a small behavioural ALU in the loop.
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_done_tick;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       timeout_tick;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(.SIZE(8), .TIMEOUT(16), .TO_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .alu_result   (alu_result),
    .tx_done_tick (tx_done_tick),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .busy         (busy),
    .timeout_tick (timeout_tick)
  );

  // Reference ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SRA 0x03, else 0.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      6'h20: alu_result = alu_a + alu_b;
      6'h22: alu_result = alu_a - alu_b;
      6'h24: alu_result = alu_a & alu_b;
      6'h25: alu_result = alu_a | alu_b;
      6'h03: alu_result = 8'($signed(alu_a) >>> alu_b);
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},  32'(alu_a), 32'h0);
    chk({tag, "_b"},  32'(alu_b), 32'h0);
    chk({tag, "_op"}, 32'(alu_op), 32'h0);
    chk({tag, "_tx"}, 32'(tx_data), 32'h0);
    chk({tag, "_ts"}, 32'(tx_start), 32'h0);
    chk({tag, "_bz"}, 32'(busy), 32'h0);
    chk({tag, "_to"}, 32'(timeout_tick), 32'h0);
  endtask

  // Sends a full frame and checks the two-cycle path to the single tx_start pulse.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    chk({tag, "_op"},    32'(alu_op), 32'(op[5:0]));
    chk({tag, "_busy0"}, 32'(busy), 32'h1);
    chk({tag, "_ts0"},   32'(tx_start), 32'h0);
    step();
    chk({tag, "_ts1"},   32'(tx_start), 32'h1);
    chk({tag, "_data"},  32'(tx_data), 32'(exp));
    step();
    chk({tag, "_ts2"},   32'(tx_start), 32'h0);
    chk({tag, "_busy2"}, 32'(busy), 32'h1);
  endtask

  task automatic finish_tx(input string tag);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    tx_done_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_all_zero("rst");

    // Basic add frame
    run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    chk("add_a", 32'(alu_a), 32'h05);
    chk("add_b", 32'(alu_b), 32'h03);
    step();
    chk("add_hold_busy", 32'(busy), 32'h1);
    finish_tx("add");

    // Subtract, with a byte dropped during WAIT_TX
    run_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    send_byte(8'h77);
    chk("drop_a", 32'(alu_a), 32'h03);
    chk("drop_busy", 32'(busy), 32'h1);
    finish_tx("sub");

    // Arithmetic shift, opcode upper bits discarded
    run_frame("sra", 8'hF0, 8'h02, 8'hC3, 8'hFC);
    chk("sra_op", 32'(alu_op), 32'h03);
    finish_tx("sra");

    // tx_done outside WAIT_TX is ignored mid-frame
    send_byte(8'h01);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    send_byte(8'h01);
    send_byte(8'h20);
    chk("stray_done_busy", 32'(busy), 32'h1);
    step();
    chk("add2_data", 32'(tx_data), 32'h02);
    chk("add2_ts", 32'(tx_start), 32'h1);
    finish_tx("add2");

    // Timeout after 16 idle cycles in WAIT_B
    send_byte(8'h09);
    for (int i = 0; i < 15; i++) begin
      chk("to_early", 32'(timeout_tick), 32'h0);
      step();
    end
    chk("to_early_last", 32'(timeout_tick), 32'h0);
    step();
    chk("to_pulse", 32'(timeout_tick), 32'h1);
    chk("to_keep_a", 32'(alu_a), 32'h09);
    step();
    chk("to_once", 32'(timeout_tick), 32'h0);
    run_frame("and", 8'h04, 8'h04, 8'h24, 8'h04);
    chk("and_a", 32'(alu_a), 32'h04);
    finish_tx("and");

    // Byte arriving exactly on the expiry cycle is accepted
    send_byte(8'h11);
    for (int i = 0; i < 15; i++) step();
    send_byte(8'h06);
    chk("edge_b", 32'(alu_b), 32'h06);
    chk("edge_no_to", 32'(timeout_tick), 32'h0);
    step();
    chk("edge_no_to2", 32'(timeout_tick), 32'h0);
    send_byte(8'h20);
    step();
    chk("edge_data", 32'(tx_data), 32'h17);
    finish_tx("edge");

    // Reset in WAIT_OP
    send_byte(8'h0A);
    send_byte(8'h0B);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rst_op");
    run_frame("post_rst", 8'h0C, 8'h01, 8'h20, 8'h0D);

    // Reset in WAIT_TX
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rst_tx");
    step();
    chk("rst_tx_no_ts", 32'(tx_start), 32'h0);
    chk("rst_tx_idle", 32'(busy), 32'h0);
    run_frame("final", 8'h02, 8'h03, 8'h20, 8'h05);
    finish_tx("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Upstream control stage between the UART receiver and the combinational ALU. It collects three consecutive received bytes (operand A, operand B, opcode), holds them on registers that drive the ALU inputs, captures the ALU result one cycle later, and hands it to the UART transmitter with a start pulse. Partial frames are abandoned after a configurable idle timeout.

## Interface
- `SIZE`, 8: data and operand width in bits; equals the UART word width and the ALU `size`.
- `TIMEOUT`, 1000000: idle clock cycles allowed between bytes of one frame; 0 disables the timeout.
- `TO_W`, 20: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_done_tick`  in  1  one-cycle pulse from the UART receiver: `rx_data` is valid.
- `rx_data`  in  SIZE  received byte.
- `alu_result`  in  SIZE  combinational result from the ALU.
- `tx_done_tick`  in  1  one-cycle pulse from the UART transmitter: the previous word has been sent.
- `alu_a`  out  SIZE  registered operand A to the ALU.
- `alu_b`  out  SIZE  registered operand B to the ALU.
- `alu_op`  out  6  registered opcode to the ALU.
- `tx_data`  out  SIZE  registered word to transmit.
- `tx_start`  out  1  one-cycle transmit request.
- `busy`  out  1  high in CALC and WAIT_TX.
- `timeout_tick`  out  1  one-cycle pulse when a partial frame is abandoned.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, CALC, WAIT_TX. Reset state is WAIT_A.
- Reset values: `alu_a`=0, `alu_b`=0, `alu_op`=0, `tx_data`=0, `tx_start`=0, `timeout_tick`=0, `busy`=0, timeout counter=0. Reset applied in any state, including mid-frame or during WAIT_TX, returns to WAIT_A with these values on the next edge.
- WAIT_A: on `rx_done_tick`, `alu_a` <= `rx_data`, then go to WAIT_B.
- WAIT_B: on tick, `alu_b` <= `rx_data`, then go to WAIT_OP.
- WAIT_OP: on tick, `alu_op` <= `rx_data[5:0]`, then go to CALC. Upper bits are discarded and the opcode is not validated; the ALU default applies.
- CALC: unconditional single cycle. `tx_data` <= `alu_result`, `tx_start` <= 1, then go to WAIT_TX.
- WAIT_TX: on `tx_done_tick`, go to WAIT_A. `rx_done_tick` in CALC or WAIT_TX is dropped. No buffering.
- `tx_done_tick` in any state other than WAIT_TX is ignored.
- Operand and opcode registers hold their values until overwritten. They are not cleared at frame end or on timeout.
- Timeout (TIMEOUT>0): the counter runs only in WAIT_B and WAIT_OP. It clears on every `rx_done_tick` and on entry to WAIT_A.
  - When the counter equals TIMEOUT-1 with no tick that cycle: state <= WAIT_A, counter <= 0, `timeout_tick` pulses the next cycle.
  - If a tick and expiry coincide, the byte is accepted and no timeout occurs.
- WAIT_A never times out.

## Timing
- Opcode tick sampled at edge E0. `alu_op` is valid after E0, and the state is CALC for the following cycle.
- `tx_data` and `tx_start`=1 are valid after E0+1.
- `tx_start` is high for exactly one cycle, then returns to 0.
- Latency from opcode tick to `tx_start`: 2 cycles.
- Next frame: the first byte is accepted in the cycle after the edge that sampled `tx_done_tick`.
- `timeout_tick` is registered and coincides with the first cycle back in WAIT_A.
- Throughput is bounded by UART: one result per three received words plus the transmit time.

## Test plan
- Reset, then bytes 0x05, 0x03, 0x20 -> `alu_a`=0x05, `alu_b`=0x03, `alu_op`=0x20. `tx_data`=0x08 and a single `tx_start` pulse 2 cycles after the opcode tick. `busy`=1 until `tx_done_tick`.
- Bytes 0x03, 0x05, 0x22 -> `tx_data`=0xFE. Then bytes 0xF0, 0x02, 0xC3 -> `alu_op`=0x03, `tx_data`=0xFC (arithmetic shift).
- During WAIT_TX, inject `rx_done_tick` with 0x77 -> `alu_a` remains 0x03. After `tx_done_tick`, frame 0x01, 0x01, 0x20 -> `tx_data`=0x02.
- With TIMEOUT=16: send 0x09, then idle 16 cycles -> `timeout_tick` pulses once, state is WAIT_A, `alu_a` stays 0x09. Next three bytes 0x04, 0x04, 0x24 -> `tx_data`=0x04.
- With TIMEOUT=16: send a byte, then a tick exactly at the expiry cycle -> byte accepted as B, no `timeout_tick`.
- Assert `reset` for one cycle in WAIT_OP and again in WAIT_TX -> all outputs 0, state WAIT_A, no `tx_start`. Then a full frame completes normally.
